// File: rtl/gpio_lite15_pkg.sv
// Shared constants, FSM state type and bus payloads for the GPIO lite subunit
// and its register-access initiator.
package gpio_lite15_pkg;

    localparam int unsigned GPIO_WIDTH  = 16;
    localparam int unsigned GPIO_ADDR_W = 6;

    localparam logic [GPIO_ADDR_W-1:0] GPIO_DIR_ADDR        = 6'h04;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_OE_ADDR         = 6'h08;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_OUT_ADDR        = 6'h0C;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_IN_ADDR         = 6'h10;
    localparam logic [GPIO_ADDR_W-1:0] GPIO_INT_STATUS_ADDR = 6'h20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } gpio_state_e;

    // Subunit-side register bus, valid for the single ACCESS cycle
    typedef struct packed {
        logic                   read;
        logic                   write;
        logic [GPIO_ADDR_W-1:0] addr;
        logic [GPIO_WIDTH-1:0]  wdata;
    } gpio_bus_t;

    typedef struct packed {
        logic                  irq;
        logic [GPIO_WIDTH-1:0] rdata;
    } gpio_rsp_t;

endpackage

// File: rtl/gpio_lite_irq_arb15.sv
// Two-requester round-robin grant (command vs interrupt service) with a
// last-grant flop; out of reset the interrupt requester wins a tie.
module gpio_lite_irq_arb15
    import gpio_lite15_pkg::*;
(
    input  logic pclk15,
    input  logic n_reset15,
    input  logic req_cmd_i,
    input  logic req_irq_i,
    input  logic take_i,
    output logic gnt_cmd_o,
    output logic gnt_irq_o
);

    logic last_irq_q;
    logic last_irq_d;

    always_comb begin
        gnt_irq_o  = req_irq_i & (~req_cmd_i | ~last_irq_q);
        gnt_cmd_o  = req_cmd_i & ~gnt_irq_o;
        last_irq_d = last_irq_q;
        // Only a grant that is actually consumed moves the fairness pointer
        if (take_i && (gnt_irq_o || gnt_cmd_o)) begin
            last_irq_d = gnt_irq_o;
        end
    end

    always_ff @(posedge pclk15 or negedge n_reset15) begin
        if (!n_reset15) begin
            last_irq_q <= 1'b0;
        end else begin
            last_irq_q <= last_irq_d;
        end
    end

endmodule

// File: rtl/gpio_lite_initiator15.sv
// Register-access initiator for one GPIO lite subunit: one command, one bus
// cycle, one response. Define GPIO_LITE_INITIATOR15_IRQ_AUTO_EN for irq auto-service.
module gpio_lite_initiator15
    import gpio_lite15_pkg::*;
(
    input  logic                   pclk15,
    input  logic                   n_reset15,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic                   cmd_write,
    input  logic [GPIO_ADDR_W-1:0] cmd_addr,
    input  logic [GPIO_WIDTH-1:0]  cmd_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [GPIO_WIDTH-1:0]  rsp_rdata,
    output logic                   rsp_irq,
    output logic                   read,
    output logic                   write,
    output logic [GPIO_ADDR_W-1:0] addr,
    output logic [GPIO_WIDTH-1:0]  wdata,
    input  logic [GPIO_WIDTH-1:0]  bus_rdata,
    input  logic [GPIO_WIDTH-1:0]  irq
);

    gpio_state_e state_q, state_d;
    gpio_bus_t   bus_q, bus_d;
    gpio_rsp_t   rsp_q, rsp_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        txn_write_q, txn_write_d;
    logic        txn_irq_q, txn_irq_d;

    logic        gnt_irq;
    logic        cmd_go;

`ifdef GPIO_LITE_INITIATOR15_IRQ_AUTO_EN
    logic gnt_cmd;

    gpio_lite_irq_arb15 u_irq_arb (
        .pclk15    (pclk15),
        .n_reset15 (n_reset15),
        .req_cmd_i (cmd_valid),
        .req_irq_i (|irq),
        .take_i    (state_q == IDLE),
        .gnt_cmd_o (gnt_cmd),
        .gnt_irq_o (gnt_irq)
    );

    assign cmd_go = gnt_cmd;
`else
    logic unused_irq;

    assign unused_irq = ^irq;
    assign gnt_irq    = 1'b0;
    assign cmd_go     = cmd_valid;
`endif

    assign cmd_ready = (state_q == IDLE) & ~gnt_irq;

    // Next-state, bus and response decode
    always_comb begin
        state_d     = state_q;
        bus_d       = '0;
        rsp_d       = '0;
        rsp_valid_d = 1'b0;
        txn_write_d = txn_write_q;
        txn_irq_d   = txn_irq_q;

        case (state_q)
            IDLE: begin
                if (gnt_irq) begin
                    state_d     = ACCESS;
                    bus_d.read  = 1'b1;
                    bus_d.addr  = GPIO_INT_STATUS_ADDR;
                    txn_write_d = 1'b0;
                    txn_irq_d   = 1'b1;
                end else if (cmd_go) begin
                    state_d     = ACCESS;
                    bus_d.read  = ~cmd_write;
                    bus_d.write = cmd_write;
                    bus_d.addr  = cmd_addr;
                    bus_d.wdata = cmd_wdata;
                    txn_write_d = cmd_write;
                    txn_irq_d   = 1'b0;
                end
            end

            ACCESS: begin
                if (txn_write_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                end else begin
                    state_d = CAPTURE;
                end
            end

            // Subunit read data is registered, so it is valid one cycle after ACCESS
            CAPTURE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_d.rdata = bus_rdata;
                rsp_d.irq   = txn_irq_q;
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_d       = rsp_q;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk15 or negedge n_reset15) begin
        if (!n_reset15) begin
            state_q     <= IDLE;
            bus_q       <= '0;
            rsp_q       <= '0;
            rsp_valid_q <= 1'b0;
            txn_write_q <= 1'b0;
            txn_irq_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_q       <= bus_d;
            rsp_q       <= rsp_d;
            rsp_valid_q <= rsp_valid_d;
            txn_write_q <= txn_write_d;
            txn_irq_q   <= txn_irq_d;
        end
    end

    assign read      = bus_q.read;
    assign write     = bus_q.write;
    assign addr      = bus_q.addr;
    assign wdata     = bus_q.wdata;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_q.rdata;
    assign rsp_irq   = rsp_q.irq;

endmodule

// File: tb/tb_gpio_lite_initiator15.sv
// Scoreboard bench for gpio_lite_initiator15 against a small behavioural
// GPIO lite subunit; irq expectations follow GPIO_LITE_INITIATOR15_IRQ_AUTO_EN.
module tb_gpio_lite_initiator15;
    import gpio_lite15_pkg::*;

    logic                   pclk15 = 1'b0;
    logic                   n_reset15;
    logic                   cmd_valid, cmd_ready, cmd_write;
    logic [GPIO_ADDR_W-1:0] cmd_addr;
    logic [GPIO_WIDTH-1:0]  cmd_wdata;
    logic                   rsp_valid, rsp_ready, rsp_irq;
    logic [GPIO_WIDTH-1:0]  rsp_rdata;
    logic                   read, write;
    logic [GPIO_ADDR_W-1:0] addr;
    logic [GPIO_WIDTH-1:0]  wdata, bus_rdata, irq;

    logic [GPIO_WIDTH-1:0]  pin_in15, pin_in_d, dir_q, oe_q, out_q, int_q, rdata_q;

    int n_checks = 0;
    int n_errors = 0;
    int bus_cnt  = 0;

    logic [23:0] exp_bus_q[$];
    logic [16:0] exp_rsp_q[$];

    always #5 pclk15 = ~pclk15;

    gpio_lite_initiator15 dut (
        .pclk15    (pclk15),
        .n_reset15 (n_reset15),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_irq   (rsp_irq),
        .read      (read),
        .write     (write),
        .addr      (addr),
        .wdata     (wdata),
        .bus_rdata (bus_rdata),
        .irq       (irq)
    );

    // Behavioural subunit: registered read data, rising-edge interrupts on dir-enabled pins
    always @(posedge pclk15 or negedge n_reset15) begin
        if (!n_reset15) begin
            dir_q <= '0; oe_q <= '0; out_q <= '0; int_q <= '0; rdata_q <= '0; pin_in_d <= '0;
        end else begin
            pin_in_d <= pin_in15;
            if (write) begin
                case (addr)
                    GPIO_DIR_ADDR: dir_q <= wdata;
                    GPIO_OE_ADDR:  oe_q  <= wdata;
                    GPIO_OUT_ADDR: out_q <= wdata;
                    default: ;
                endcase
            end
            rdata_q <= '0;
            if (read) begin
                case (addr)
                    GPIO_DIR_ADDR:        rdata_q <= dir_q;
                    GPIO_OE_ADDR:         rdata_q <= oe_q;
                    GPIO_OUT_ADDR:        rdata_q <= out_q;
                    GPIO_IN_ADDR:         rdata_q <= pin_in15;
                    GPIO_INT_STATUS_ADDR: rdata_q <= int_q;
                    default:              rdata_q <= '0;
                endcase
            end
            int_q <= ((read && addr == GPIO_INT_STATUS_ADDR) ? '0 : int_q)
                     | (pin_in15 & ~pin_in_d & dir_q);
        end
    end

    assign bus_rdata = rdata_q;
    assign irq       = int_q;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic rd, input logic wr, input logic [5:0] a,
                            input logic [15:0] d, input logic ri, input logic [15:0] rdat);
        exp_bus_q.push_back({rd, wr, a, d});
        exp_rsp_q.push_back({ri, rdat});
    endtask

    // Every bus cycle must match the next expected one
    always @(negedge pclk15) begin
        if (n_reset15 && (read || write)) begin
            bus_cnt++;
            if (exp_bus_q.size() == 0) check_eq("bus_unexpected", 32'(exp_bus_q.size()), 32'd1);
            else check_eq("bus_op", 32'({read, write, addr, wdata}), 32'(exp_bus_q.pop_front()));
        end
    end

    always @(negedge pclk15) begin
        if (n_reset15 && rsp_valid && rsp_ready) begin
            if (exp_rsp_q.size() == 0) check_eq("rsp_unexpected", 32'(exp_rsp_q.size()), 32'd1);
            else check_eq("rsp_irq_rdata", 32'({rsp_irq, rsp_rdata}), 32'(exp_rsp_q.pop_front()));
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again
    task automatic do_cmd(input logic wr, input logic [5:0] a, input logic [15:0] d,
                          input logic [15:0] exp_rd);
        int n;
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
        push_exp(~wr, wr, a, d, 1'b0, wr ? 16'h0 : exp_rd);
        n = 0;
        @(negedge pclk15);
        while (!cmd_ready && n < 40) begin @(negedge pclk15); n++; end
        check_eq("cmd_accept", 32'(cmd_ready), 32'd1);
        @(posedge pclk15); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge pclk15); n++; end
        check_eq(wr ? "write_latency" : "read_latency", 32'(n), wr ? 32'd2 : 32'd3);
        @(posedge pclk15); #1;
    endtask

    task automatic wait_rsp_drain();
        int n;
        n = 0;
        while (exp_rsp_q.size() != 0 && n < 60) begin @(negedge pclk15); n++; end
        check_eq("rsp_drain", 32'(exp_rsp_q.size()), 32'd0);
        @(posedge pclk15); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int b;
        n_reset15 = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b1; pin_in15 = 16'h1200;
        repeat (3) @(posedge pclk15);
        #1;
        check_eq("rst_bus", 32'({read, write, addr, wdata}), 32'd0);
        check_eq("rst_rsp", 32'({rsp_valid, rsp_irq, rsp_rdata}), 32'd0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        n_reset15 = 1'b1;
        @(posedge pclk15); #1;

        do_cmd(1'b1, GPIO_OUT_ADDR, 16'hA5A5, 16'h0);
        check_eq("pin_out", 32'(out_q), 32'hA5A5);
        do_cmd(1'b1, GPIO_DIR_ADDR, 16'h00FF, 16'h0);
        do_cmd(1'b0, GPIO_DIR_ADDR, 16'h0, 16'h00FF);
        do_cmd(1'b0, GPIO_IN_ADDR, 16'h0, 16'h1200);

        // Backpressure: response held stable, no new bus cycles
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = GPIO_OUT_ADDR; cmd_wdata = '0;
        push_exp(1'b1, 1'b0, GPIO_OUT_ADDR, 16'h0, 1'b0, 16'hA5A5);
        n = 0;
        @(negedge pclk15);
        while (!cmd_ready && n < 40) begin @(negedge pclk15); n++; end
        @(posedge pclk15); #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin @(negedge pclk15); n++; end
        b = bus_cnt;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_rdata", 32'(rsp_rdata), 32'hA5A5);
            check_eq("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge pclk15);
        end
        check_eq("bp_no_bus", 32'(bus_cnt), 32'(b));
        @(posedge pclk15); #1;
        rsp_ready = 1'b1;
        @(posedge pclk15); #1;
        check_eq("bp_idle_ready", 32'(cmd_ready), 32'd1);
        check_eq("bp_idle_valid", 32'(rsp_valid), 32'd0);
        @(posedge pclk15); #1;

        do_cmd(1'b1, GPIO_DIR_ADDR, 16'h0001, 16'h0);
`ifdef GPIO_LITE_INITIATOR15_IRQ_AUTO_EN
        // Interrupt auto-read of int status
        pin_in15 = 16'h1201;
        push_exp(1'b1, 1'b0, GPIO_INT_STATUS_ADDR, 16'h0, 1'b1, 16'h0001);
        wait_rsp_drain();
        check_eq("irq_cleared", 32'(irq), 32'd0);

        // Round-robin: irq first out of reset, then the command
        n_reset15 = 1'b0; pin_in15 = '0;
        repeat (2) @(posedge pclk15);
        #1 n_reset15 = 1'b1;
        @(posedge pclk15); #1;
        do_cmd(1'b1, GPIO_DIR_ADDR, 16'h0003, 16'h0);
        pin_in15 = 16'h0001;
        @(posedge pclk15); #1;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = GPIO_DIR_ADDR; cmd_wdata = '0;
        push_exp(1'b1, 1'b0, GPIO_INT_STATUS_ADDR, 16'h0, 1'b1, 16'h0001);
        push_exp(1'b1, 1'b0, GPIO_DIR_ADDR, 16'h0, 1'b0, 16'h0003);
        push_exp(1'b1, 1'b0, GPIO_INT_STATUS_ADDR, 16'h0, 1'b1, 16'h0002);
        @(negedge pclk15);
        check_eq("arb_first_irq", 32'(cmd_ready), 32'd0);
        @(posedge pclk15); #1;
        pin_in15 = 16'h0003;
        n = 0;
        @(negedge pclk15);
        while (!cmd_ready && n < 40) begin @(negedge pclk15); n++; end
        check_eq("arb_second_cmd", 32'(cmd_ready), 32'd1);
        check_eq("arb_irq_pending", 32'(irq), 32'h0002);
        @(posedge pclk15); #1;
        cmd_valid = 1'b0;
        wait_rsp_drain();
        check_eq("arb_irq_cleared", 32'(irq), 32'd0);
`else
        // Interrupt ignored: command path stays open, no auto-read
        pin_in15 = 16'h1201;
        b = bus_cnt;
        repeat (4) begin
            @(negedge pclk15);
            check_eq("noirq_cmd_ready", 32'(cmd_ready), 32'd1);
        end
        check_eq("noirq_no_bus", 32'(bus_cnt), 32'(b));
        @(posedge pclk15); #1;
        do_cmd(1'b0, GPIO_INT_STATUS_ADDR, 16'h0, 16'h0001);
        check_eq("noirq_cleared", 32'(irq), 32'd0);
`endif

        // Reset during CAPTURE drops the transaction
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = GPIO_DIR_ADDR; cmd_wdata = '0;
        exp_bus_q.push_back({1'b1, 1'b0, GPIO_DIR_ADDR, 16'h0});
        n = 0;
        @(negedge pclk15);
        while (!cmd_ready && n < 40) begin @(negedge pclk15); n++; end
        @(posedge pclk15); #1;
        cmd_valid = 1'b0;
        @(posedge pclk15); #1;
        n_reset15 = 1'b0;
        #1;
        check_eq("rstcap_bus", 32'({read, write, addr, wdata}), 32'd0);
        check_eq("rstcap_rsp", 32'({rsp_valid, rsp_irq, rsp_rdata}), 32'd0);
        repeat (2) @(posedge pclk15);
        @(negedge pclk15);
        check_eq("rstcap_no_rsp", 32'(rsp_valid), 32'd0);
        @(posedge pclk15); #1;
        n_reset15 = 1'b1;
        @(posedge pclk15); #1;
        do_cmd(1'b1, GPIO_OUT_ADDR, 16'h5A5A, 16'h0);
        do_cmd(1'b0, GPIO_OUT_ADDR, 16'h0, 16'h5A5A);

        repeat (3) @(posedge pclk15);
        check_eq("bus_queue_empty", 32'(exp_bus_q.size()), 32'd0);
        check_eq("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
